// File: rtl/ph_pkg.sv
// Shared types and defaults for the blood-pH monitor: FSM state encoding,
// default band limits and the per-sample flag payload.
package ph_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_WARN   = 2'd1,
    ST_CRIT   = 2'd2,
    ST_RSVD   = 2'd3
  } ph_state_e;

  localparam int unsigned DEF_DATA_W   = 4;
  localparam int unsigned DEF_TIGHT_LO = 7;
  localparam int unsigned DEF_TIGHT_HI = 8;
  localparam int unsigned DEF_WIDE_LO  = 6;
  localparam int unsigned DEF_WIDE_HI  = 9;
  localparam int unsigned DEF_PERSIST  = 3;

  typedef struct packed {
    logic abn_p;
    logic abn_q;
  } ph_flags_t;

endpackage

// File: rtl/blood_ph_monitor_if.sv
// Sample-in / classification-out bundle between the sensor stage, the
// monitor and the alarm aggregator.
interface blood_ph_monitor_if #(
  parameter int unsigned DATA_W = 4
);

  logic              sample_valid;
  logic [DATA_W-1:0] sample_ph;
  logic              alarm_clear;
  logic              out_valid;
  logic              abn_p;
  logic              abn_q;
  logic              alarm_warn;
  logic              alarm_crit;
  logic [1:0]        state;

  modport master (
    output sample_valid, sample_ph, alarm_clear,
    input  out_valid, abn_p, abn_q, alarm_warn, alarm_crit, state
  );

  modport slave (
    input  sample_valid, sample_ph, alarm_clear,
    output out_valid, abn_p, abn_q, alarm_warn, alarm_crit, state
  );

endinterface

// File: rtl/ph_band_check.sv
// Combinational inclusive band compare: o_in_band_c = LO <= i_ph <= HI.
// Limits sitting on the range ends collapse to constants instead of tautological compares.
module ph_band_check #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned LO     = 7,
  parameter int unsigned HI     = 8
) (
  input  logic [DATA_W-1:0] i_ph,
  output logic              o_in_band_c
);

  localparam longint unsigned PH_MAX = (64'd1 << DATA_W) - 64'd1;

  logic w_lo_ok;
  logic w_hi_ok;

  generate
    if (LO == 0) begin : g_lo_open
      assign w_lo_ok = 1'b1;
    end else begin : g_lo_cmp
      assign w_lo_ok = (i_ph >= DATA_W'(LO));
    end

    if (64'(HI) >= PH_MAX) begin : g_hi_open
      assign w_hi_ok = 1'b1;
    end else begin : g_hi_cmp
      assign w_hi_ok = (i_ph <= DATA_W'(HI));
    end
  endgenerate

  assign o_in_band_c = w_lo_ok & w_hi_ok;

endmodule

// File: rtl/blood_ph_monitor.sv
// Classifies each pH sample against tight (P) and wide (Q) bands and confirms
// persistent abnormality through saturating run counters and a WARN/CRITICAL FSM.
module blood_ph_monitor
  import ph_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned TIGHT_LO = DEF_TIGHT_LO,
  parameter int unsigned TIGHT_HI = DEF_TIGHT_HI,
  parameter int unsigned WIDE_LO  = DEF_WIDE_LO,
  parameter int unsigned WIDE_HI  = DEF_WIDE_HI,
  parameter int unsigned PERSIST  = DEF_PERSIST
) (
  input logic              clk,
  input logic              rst_n,
  blood_ph_monitor_if.slave bus
);

  localparam int unsigned     CNT_W   = $clog2(PERSIST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERSIST);
  localparam longint unsigned PH_MAX  = (64'd1 << DATA_W) - 64'd1;

  generate
    if (DATA_W < 2 || PERSIST == 0 || WIDE_LO > TIGHT_LO || TIGHT_LO > TIGHT_HI ||
        TIGHT_HI > WIDE_HI || 64'(WIDE_HI) > PH_MAX) begin : g_bad_cfg
      $error("blood_ph_monitor: band limits must satisfy WIDE_LO<=TIGHT_LO<=TIGHT_HI<=WIDE_HI<=2**DATA_W-1");
    end
  endgenerate

  logic             w_in_p;
  logic             w_in_q;
  logic             w_p_out;
  logic             w_q_out;
  logic [CNT_W-1:0] w_cnt_p_nxt;
  logic [CNT_W-1:0] w_cnt_q_nxt;
  ph_state_e        w_state_nxt;

  logic [CNT_W-1:0] r_cnt_p;
  logic [CNT_W-1:0] r_cnt_q;
  ph_state_e        r_state;
  ph_flags_t        r_flags;
  logic             r_out_valid;
  logic             r_warn;
  logic             r_crit;

  ph_band_check #(.DATA_W(DATA_W), .LO(TIGHT_LO), .HI(TIGHT_HI)) u_band_p (
    .i_ph        (bus.sample_ph),
    .o_in_band_c (w_in_p)
  );

  ph_band_check #(.DATA_W(DATA_W), .LO(WIDE_LO), .HI(WIDE_HI)) u_band_q (
    .i_ph        (bus.sample_ph),
    .o_in_band_c (w_in_q)
  );

  assign w_p_out = ~w_in_p;
  assign w_q_out = ~w_in_q;

  // Saturating run lengths of consecutive out-of-band samples
  always_comb begin
    w_cnt_p_nxt = '0;
    w_cnt_q_nxt = '0;
    if (w_p_out) begin
      w_cnt_p_nxt = (r_cnt_p == CNT_MAX) ? r_cnt_p : r_cnt_p + CNT_W'(1);
    end
    if (w_q_out) begin
      w_cnt_q_nxt = (r_cnt_q == CNT_MAX) ? r_cnt_q : r_cnt_q + CNT_W'(1);
    end
  end

  // Transitions look at post-update counts; clear overrides any sample
  always_comb begin
    w_state_nxt = r_state;
    if (bus.alarm_clear) begin
      w_state_nxt = ST_NORMAL;
    end else if (bus.sample_valid) begin
      case (r_state)
        ST_NORMAL: begin
          if (w_cnt_q_nxt == CNT_MAX)      w_state_nxt = ST_CRIT;
          else if (w_cnt_p_nxt == CNT_MAX) w_state_nxt = ST_WARN;
        end
        ST_WARN: begin
          if (w_cnt_q_nxt == CNT_MAX) w_state_nxt = ST_CRIT;
          else if (!w_p_out)          w_state_nxt = ST_NORMAL;
        end
        ST_CRIT:  w_state_nxt = ST_CRIT;
        default:  w_state_nxt = ST_NORMAL;
      endcase
    end else if (r_state == ST_RSVD) begin
      w_state_nxt = ST_NORMAL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_NORMAL;
      r_cnt_p     <= '0;
      r_cnt_q     <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
      r_warn      <= 1'b0;
      r_crit      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_warn      <= (w_state_nxt == ST_WARN);
      r_crit      <= (w_state_nxt == ST_CRIT);
      r_out_valid <= bus.sample_valid & ~bus.alarm_clear;
      if (bus.alarm_clear) begin
        r_cnt_p <= '0;
        r_cnt_q <= '0;
      end else if (bus.sample_valid) begin
        r_cnt_p <= w_cnt_p_nxt;
        r_cnt_q <= w_cnt_q_nxt;
        r_flags <= '{abn_p: w_p_out, abn_q: w_q_out};
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.abn_p      = r_flags.abn_p;
  assign bus.abn_q      = r_flags.abn_q;
  assign bus.alarm_warn = r_warn;
  assign bus.alarm_crit = r_crit;
  assign bus.state      = r_state;

endmodule
